vending_machine_multi: RTL

Parametrised successor to the two-product vending controller. It supports NUM_ITEMS products with individually configured prices and a wider credit register. It adds a cancel/refund path, a change amount bus, coin rejection on overflow, and rising-edge detection of the level-held coin and selection inputs. It sits between the coin/button front panel and the dispense and change actuators.

---
 rtl/vm_controller.sv | 4 +
 rtl/vm_defs.sv | 15 +
 rtl/vm_edge_detect.sv | 21 ++
 rtl/vending_machine_multi.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/vm_controller.sv
// The top level is in vending_machine_multi.sv.
// This file holds no logic.
package vm_controller_files;
endpackage

// File: rtl/vm_defs.sv
// Shared definitions for the multi-product vending controller:
// coin values and controller state encoding.
package vm_defs;

  localparam int unsigned NICKEL_VAL  = 5;
  localparam int unsigned DIME_VAL    = 10;
  localparam int unsigned QUARTER_VAL = 25;

  typedef enum logic [1:0] {
    ACCUM    = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2
  } state_t;

endpackage

// File: rtl/vm_edge_detect.sv
// Rising-edge detector for level-held front-panel inputs. History resets to
// all ones so an input already high when reset releases raises no event.
module vm_edge_detect #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= '1;
    else     prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: credit accumulation, priced dispense,
// change/refund output and coin rejection on overflow.
module vending_machine_multi
  import vm_defs::*;
#(
  parameter int                          NUM_ITEMS  = 4,
  parameter int                          CREDIT_W   = 8,
  parameter int                          MAX_CREDIT = 200,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_LIST = {8'd75, 8'd65, 8'd50, 8'd35}
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 ni,
  input  logic                 di,
  input  logic                 qu,
  input  logic [NUM_ITEMS-1:0] sel,
  input  logic                 cancel,
  output logic [NUM_ITEMS-1:0] give,
  output logic                 change_valid,
  output logic [CREDIT_W-1:0]  change_amt,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 coin_reject,
  output logic                 short_funds,
  output logic                 busy
);

  localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);

  logic [CREDIT_W-1:0] price [NUM_ITEMS];

  generate
    if (MAX_CREDIT >= (2 ** CREDIT_W)) begin : g_max_chk
      $error("MAX_CREDIT does not fit in CREDIT_W bits");
    end
    for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_price
      assign price[g] = PRICE_LIST[g*CREDIT_W +: CREDIT_W];
      if (PRICE_LIST[g*CREDIT_W +: CREDIT_W] > MAX_CREDIT) begin : g_price_chk
        $error("price exceeds MAX_CREDIT");
      end
    end
  endgenerate

  logic [NUM_ITEMS+3:0] ev;
  logic                 ni_ev, di_ev, qu_ev, cancel_ev, coin_any, coin_multi;
  logic [NUM_ITEMS-1:0] sel_ev;

  vm_edge_detect #(.WIDTH(NUM_ITEMS + 4)) u_edge (
    .clk   (CLK),
    .rst   (rst),
    .level ({cancel, sel, qu, di, ni}),
    .rise  (ev)
  );

  assign ni_ev      = ev[0];
  assign di_ev      = ev[1];
  assign qu_ev      = ev[2];
  assign sel_ev     = ev[3 +: NUM_ITEMS];
  assign cancel_ev  = ev[NUM_ITEMS+3];
  assign coin_any   = ni_ev | di_ev | qu_ev;
  assign coin_multi = (qu_ev & (di_ev | ni_ev)) | (di_ev & ni_ev);

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [IDX_W-1:0]    item, item_nxt;
  logic                reject_nxt, short_nxt;

  // Lowest-index rising select wins.
  logic                sel_found;
  logic [IDX_W-1:0]    sel_idx;
  logic [CREDIT_W-1:0] sel_price;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_price = '0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      if (sel_ev[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_price = price[i];
      end
    end
  end

  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;

  always_comb begin
    if (qu_ev)      coin_val = CREDIT_W'(QUARTER_VAL);
    else if (di_ev) coin_val = CREDIT_W'(DIME_VAL);
    else            coin_val = CREDIT_W'(NICKEL_VAL);
    coin_sum = {1'b0, credit} + {1'b0, coin_val};
  end

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    item_nxt   = item;
    reject_nxt = 1'b0;
    short_nxt  = 1'b0;
    case (state)
      ACCUM: begin
        if (cancel_ev) begin
          reject_nxt = coin_any;
          if (credit != '0) state_nxt = CHANGE;
        end else if (sel_found) begin
          reject_nxt = coin_any;
          if (credit >= sel_price) begin
            state_nxt  = DISPENSE;
            item_nxt   = sel_idx;
            credit_nxt = credit - sel_price;
          end else begin
            short_nxt = 1'b1;
          end
        end else if (coin_any) begin
          if (coin_sum <= MAX_SUM) begin
            credit_nxt = coin_sum[CREDIT_W-1:0];
            reject_nxt = coin_multi;
          end else begin
            reject_nxt = 1'b1;
          end
        end
      end
      DISPENSE: begin
        reject_nxt = coin_any;
        state_nxt  = (credit != '0) ? CHANGE : ACCUM;
      end
      CHANGE: begin
        reject_nxt = coin_any;
        credit_nxt = '0;
        state_nxt  = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state       <= ACCUM;
      credit      <= '0;
      item        <= '0;
      coin_reject <= 1'b0;
      short_funds <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      item        <= item_nxt;
      coin_reject <= reject_nxt;
      short_funds <= short_nxt;
    end
  end

  always_comb begin
    give = '0;
    if (state == DISPENSE) give[item] = 1'b1;
  end

  assign change_valid = (state == CHANGE);
  assign change_amt   = change_valid ? credit : '0;
  assign busy         = (state != ACCUM);

endmodule
